dmac_req_ctrl: RTL and testbench

//  Control FSM directly upstream of the DMAC main datapath; drives every datapath control input.

---
 rtl/dmac_pkg.sv | 25 ++
 rtl/dmac_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmac_req_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types and constants for the DMAC request controller
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        SEL,
        XFER,
        DONE,
        ERR
    } dmac_ctrl_state_e;

    // Descriptor is always four words: SAddr, DAddr, Size, Ctrl
    localparam logic [2:0] CFG_WORDS     = 3'd4;
    localparam logic [1:0] CFG_LAST_WORD = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [1:0] CON_SEL_CH1   = 2'b00;
    localparam logic [1:0] CON_SEL_CH2   = 2'b01;
    localparam logic [1:0] CON_SEL_CFG   = 2'b10;

endpackage

// File: rtl/dmac_req_ctrl.sv
// rtl/dmac_req_ctrl.sv - request/descriptor-fetch/channel control FSM for the DMAC datapath
module dmac_req_ctrl
    import dmac_pkg::*;
#(
    parameter int ACK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] DmacReq,
    input  logic       HReady,
    input  logic [1:0] M_HResp,
    input  logic       C_config,
    input  logic       irq,
    input  logic [1:0] con_new_sel,
    input  logic [1:0] DmacReq_Reg,
    output logic       DmacReq_Reg_en,
    output logic       PeriAddr_reg_en,
    output logic       SAddr_Reg_en,
    output logic       DAddr_Reg_en,
    output logic       Trans_sz_Reg_en,
    output logic       Ctrl_Reg_en,
    output logic [1:0] addr_inc_sel,
    output logic [1:0] config_HTrans,
    output logic       config_write,
    output logic [1:0] con_sel,
    output logic       con_en,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic [1:0] DmacAck,
    output logic       dmac_busy,
    output logic       dmac_err
);

    localparam logic [1:0] ACK_LAST = 2'(ACK_CYCLES - 1);

    dmac_ctrl_state_e state_q;
    logic [2:0]       a_cnt_q;
    logic [1:0]       d_cnt_q;
    logic             dvalid_q;
    logic [1:0]       ack_cnt_q;

    logic             in_cfg;
    logic             hresp_err;
    logic             word_en;
    logic             addr_open;

    assign in_cfg    = (state_q == CFG);
    assign hresp_err = in_cfg && dvalid_q && (M_HResp == HRESP_ERROR);
    assign word_en   = in_cfg && dvalid_q && HReady && !hresp_err;
    assign addr_open = (a_cnt_q < CFG_WORDS);

    // Sequencing: latch request, pipelined descriptor fetch, channel run, ack or error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_cnt_q   <= '0;
            d_cnt_q   <= '0;
            dvalid_q  <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|DmacReq) begin
                        state_q  <= CFG;
                        a_cnt_q  <= '0;
                        d_cnt_q  <= '0;
                        dvalid_q <= 1'b0;
                    end
                end
                CFG: begin
                    if (hresp_err) begin
                        state_q <= ERR;
                    end else if (HReady) begin
                        if (addr_open) begin
                            a_cnt_q <= a_cnt_q + 3'd1;
                        end
                        dvalid_q <= addr_open;
                        if (dvalid_q) begin
                            d_cnt_q <= d_cnt_q + 2'd1;
                            if (d_cnt_q == CFG_LAST_WORD) begin
                                state_q <= SEL;
                            end
                        end
                    end
                end
                SEL: begin
                    state_q <= XFER;
                end
                XFER: begin
                    ack_cnt_q <= '0;
                    if (irq) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (ack_cnt_q == ACK_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 2'd1;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Datapath controls decoded from state, counters and the live AHB handshake
    always_comb begin
        DmacReq_Reg_en  = (state_q == IDLE) && (|DmacReq);
        PeriAddr_reg_en = (state_q == IDLE) && (|DmacReq);
        SAddr_Reg_en    = word_en && (d_cnt_q == 2'd0);
        DAddr_Reg_en    = word_en && (d_cnt_q == 2'd1);
        Trans_sz_Reg_en = word_en && (d_cnt_q == 2'd2);
        Ctrl_Reg_en     = word_en && (d_cnt_q == 2'd3);
        addr_inc_sel    = in_cfg ? a_cnt_q[1:0] : 2'd0;
        config_HTrans   = (in_cfg && addr_open && !hresp_err) ? HTRANS_NONSEQ : HTRANS_IDLE;
        config_write    = 1'b0;
        con_sel         = CON_SEL_CFG;
        con_en          = 1'b0;
        channel_en_1    = 1'b0;
        channel_en_2    = 1'b0;
        DmacAck         = 2'b00;
        dmac_busy       = (state_q != IDLE);
        dmac_err        = (state_q == ERR);
        case (state_q)
            SEL: begin
                con_sel = {1'b0, C_config};
                con_en  = 1'b1;
            end
            XFER: begin
                // A corrupt 2'b11 select must never reach the datapath mux
                con_sel      = (con_new_sel == 2'b11) ? CON_SEL_CFG : con_new_sel;
                channel_en_1 = (con_new_sel == CON_SEL_CH1);
                channel_en_2 = (con_new_sel == CON_SEL_CH2);
            end
            DONE: begin
                // Peripheral @0x1000 is served first when both were latched
                if (DmacReq_Reg[1]) begin
                    DmacAck = 2'b10;
                end else if (DmacReq_Reg[0]) begin
                    DmacAck = 2'b01;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmac_req_ctrl.sv
// tb/tb_dmac_req_ctrl.sv - directed self-checking bench for dmac_req_ctrl
module tb_dmac_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] DmacReq;
    logic       HReady;
    logic [1:0] M_HResp;
    logic       C_config;
    logic       irq;
    logic [1:0] con_new_sel;
    logic [1:0] DmacReq_Reg;
    logic       DmacReq_Reg_en, PeriAddr_reg_en;
    logic       SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en;
    logic [1:0] addr_inc_sel, config_HTrans, con_sel, DmacAck;
    logic       config_write, con_en, channel_en_1, channel_en_2, dmac_busy, dmac_err;
    logic [3:0] wen;

    int checks = 0;
    int errors = 0;

    dmac_req_ctrl #(.ACK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .DmacReq(DmacReq), .HReady(HReady), .M_HResp(M_HResp),
        .C_config(C_config), .irq(irq), .con_new_sel(con_new_sel), .DmacReq_Reg(DmacReq_Reg),
        .DmacReq_Reg_en(DmacReq_Reg_en), .PeriAddr_reg_en(PeriAddr_reg_en),
        .SAddr_Reg_en(SAddr_Reg_en), .DAddr_Reg_en(DAddr_Reg_en),
        .Trans_sz_Reg_en(Trans_sz_Reg_en), .Ctrl_Reg_en(Ctrl_Reg_en),
        .addr_inc_sel(addr_inc_sel), .config_HTrans(config_HTrans), .config_write(config_write),
        .con_sel(con_sel), .con_en(con_en), .channel_en_1(channel_en_1), .channel_en_2(channel_en_2),
        .DmacAck(DmacAck), .dmac_busy(dmac_busy), .dmac_err(dmac_err)
    );

    always #5 clk = ~clk;

    assign wen = {Ctrl_Reg_en, Trans_sz_Reg_en, DAddr_Reg_en, SAddr_Reg_en};

    // Datapath stand-in: request latch and registered channel select
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            DmacReq_Reg <= 2'b00;
            con_new_sel <= 2'b10;
        end else begin
            if (DmacReq_Reg_en) DmacReq_Reg <= DmacReq;
            if (con_en) con_new_sel <= con_sel;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; DmacReq = 2'b00; HReady = 1'b1; M_HResp = 2'b00; C_config = 1'b0; irq = 1'b0;
        cyc(); #4;
        checks++; if (dmac_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", dmac_busy); end
        checks++; if (con_sel !== 2'b10) begin errors++; $display("FAIL rst_con_sel got %b exp 10", con_sel); end
        checks++; if (config_HTrans !== 2'b00) begin errors++; $display("FAIL rst_htrans got %b exp 00", config_HTrans); end
        checks++; if ({wen, con_en, channel_en_1, channel_en_2, DmacAck, dmac_err, config_write} !== 11'd0) begin errors++; $display("FAIL rst_outs got %b exp 0", {wen, con_en, channel_en_1, channel_en_2, DmacAck, dmac_err, config_write}); end
        cyc();
        #2 rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [1:0] exp_ht;
        logic [3:0] exp_wen;
        cyc(); DmacReq = 2'b01; HReady = 1'b1; C_config = 1'b0; #4;
        checks++; if ({DmacReq_Reg_en, PeriAddr_reg_en} !== 2'b11) begin errors++; $display("FAIL nom_latch got %b exp 11", {DmacReq_Reg_en, PeriAddr_reg_en}); end
        checks++; if (dmac_busy !== 1'b0) begin errors++; $display("FAIL nom_t0_busy got %b exp 0", dmac_busy); end
        for (int i = 0; i < 5; i++) begin
            cyc(); DmacReq = 2'b00; #4;
            exp_ht  = (i < 4) ? 2'b10 : 2'b00;
            exp_wen = (i == 0) ? 4'b0000 : (4'b0001 << (i - 1));
            if (i < 4) begin
                checks++; if (addr_inc_sel !== 2'(i)) begin errors++; $display("FAIL nom_addr t%0d got %0d exp %0d", i + 1, addr_inc_sel, i); end
            end
            checks++; if (config_HTrans !== exp_ht) begin errors++; $display("FAIL nom_htrans t%0d got %b exp %b", i + 1, config_HTrans, exp_ht); end
            checks++; if (wen !== exp_wen) begin errors++; $display("FAIL nom_wen t%0d got %b exp %b", i + 1, wen, exp_wen); end
            checks++; if ({con_sel, dmac_busy} !== 3'b101) begin errors++; $display("FAIL nom_cfg t%0d got %b exp 101", i + 1, {con_sel, dmac_busy}); end
        end
        cyc(); #4;
        checks++; if ({con_sel, con_en} !== 3'b001) begin errors++; $display("FAIL nom_sel got %b exp 001", {con_sel, con_en}); end
        cyc(); #4;
        checks++; if ({channel_en_1, channel_en_2, con_sel} !== 4'b1000) begin errors++; $display("FAIL nom_xfer got %b exp 1000", {channel_en_1, channel_en_2, con_sel}); end
        cyc(); irq = 1'b1; #4;
        checks++; if (channel_en_1 !== 1'b1) begin errors++; $display("FAIL nom_irq_cycle got %b exp 1", channel_en_1); end
        cyc(); irq = 1'b0; #4;
        checks++; if ({DmacAck, channel_en_1, dmac_busy, con_sel} !== 6'b010110) begin errors++; $display("FAIL nom_done got %b exp 010110", {DmacAck, channel_en_1, dmac_busy, con_sel}); end
        cyc(); #4;
        checks++; if ({DmacAck, dmac_busy} !== 3'b000) begin errors++; $display("FAIL nom_idle got %b exp 000", {DmacAck, dmac_busy}); end
    endtask

    task automatic test_channel2();
        cyc(); DmacReq = 2'b10; C_config = 1'b1; #4;
        for (int i = 0; i < 5; i++) begin cyc(); DmacReq = 2'b00; end
        cyc(); #4;
        checks++; if ({con_sel, con_en} !== 3'b011) begin errors++; $display("FAIL ch2_sel got %b exp 011", {con_sel, con_en}); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #4;
            checks++; if ({channel_en_1, channel_en_2, con_sel} !== 4'b0101) begin errors++; $display("FAIL ch2_xfer c%0d got %b exp 0101", i, {channel_en_1, channel_en_2, con_sel}); end
        end
        cyc(); irq = 1'b1; #4;
        cyc(); irq = 1'b0; C_config = 1'b0; #4;
        checks++; if ({DmacAck, channel_en_2} !== 3'b100) begin errors++; $display("FAIL ch2_ack got %b exp 100", {DmacAck, channel_en_2}); end
        cyc(); #4;
        checks++; if ({DmacAck, dmac_busy} !== 3'b000) begin errors++; $display("FAIL ch2_idle got %b exp 000", {DmacAck, dmac_busy}); end
    endtask

    task automatic test_hready_stall();
        cyc(); DmacReq = 2'b01; #4;
        cyc(); DmacReq = 2'b00; #4;
        cyc(); #4;
        checks++; if (wen !== 4'b0001) begin errors++; $display("FAIL stall_d0 got %b exp 0001", wen); end
        for (int i = 0; i < 2; i++) begin
            cyc(); HReady = 1'b0; #4;
            checks++; if ({addr_inc_sel, config_HTrans, wen} !== 8'b1010_0000) begin errors++; $display("FAIL stall_hold c%0d got %b exp 10100000", i, {addr_inc_sel, config_HTrans, wen}); end
        end
        cyc(); HReady = 1'b1; #4;
        checks++; if ({addr_inc_sel, wen} !== 6'b10_0010) begin errors++; $display("FAIL stall_d1 got %b exp 100010", {addr_inc_sel, wen}); end
        cyc(); #4;
        checks++; if ({addr_inc_sel, wen} !== 6'b11_0100) begin errors++; $display("FAIL stall_d2 got %b exp 110100", {addr_inc_sel, wen}); end
        cyc(); #4;
        checks++; if (wen !== 4'b1000) begin errors++; $display("FAIL stall_d3 got %b exp 1000", wen); end
        cyc(); #4;
        checks++; if (con_en !== 1'b1) begin errors++; $display("FAIL stall_sel_t8 got %b exp 1", con_en); end
        cyc(); #4;
        cyc(); irq = 1'b1; #4;
        cyc(); irq = 1'b0; #4;
        checks++; if (DmacAck !== 2'b01) begin errors++; $display("FAIL stall_ack got %b exp 01", DmacAck); end
        cyc(); #4;
    endtask

    task automatic test_hresp_error();
        cyc(); DmacReq = 2'b01; #4;
        cyc(); DmacReq = 2'b00; #4;
        cyc(); #4;
        cyc(); #4;
        checks++; if (wen !== 4'b0010) begin errors++; $display("FAIL err_d1 got %b exp 0010", wen); end
        cyc(); M_HResp = 2'b01; #4;
        checks++; if ({wen, config_HTrans} !== 6'b0000_00) begin errors++; $display("FAIL err_d2 got %b exp 000000", {wen, config_HTrans}); end
        cyc(); M_HResp = 2'b00; #4;
        checks++; if ({dmac_err, dmac_busy, channel_en_1, channel_en_2, DmacAck} !== 6'b110000) begin errors++; $display("FAIL err_pulse got %b exp 110000", {dmac_err, dmac_busy, channel_en_1, channel_en_2, DmacAck}); end
        cyc(); #4;
        checks++; if ({dmac_err, dmac_busy, con_sel} !== 4'b0010) begin errors++; $display("FAIL err_idle got %b exp 0010", {dmac_err, dmac_busy, con_sel}); end
    endtask

    task automatic test_back_to_back();
        cyc(); DmacReq = 2'b11; C_config = 1'b0; #4;
        checks++; if (DmacReq_Reg_en !== 1'b1) begin errors++; $display("FAIL both_latch got %b exp 1", DmacReq_Reg_en); end
        cyc(); #4;
        checks++; if (DmacReq_Reg !== 2'b11) begin errors++; $display("FAIL both_reg got %b exp 11", DmacReq_Reg); end
        for (int i = 0; i < 6; i++) begin
            cyc(); #4;
            checks++; if ({DmacReq_Reg_en, PeriAddr_reg_en} !== 2'b00) begin errors++; $display("FAIL both_ignored c%0d got %b exp 00", i, {DmacReq_Reg_en, PeriAddr_reg_en}); end
        end
        cyc(); irq = 1'b1; #4;
        cyc(); irq = 1'b0; #4;
        checks++; if ({DmacAck, DmacReq_Reg_en} !== 3'b100) begin errors++; $display("FAIL both_ack got %b exp 100", {DmacAck, DmacReq_Reg_en}); end
        cyc(); #4;
        checks++; if ({DmacAck, DmacReq_Reg_en} !== 3'b001) begin errors++; $display("FAIL both_relatch got %b exp 001", {DmacAck, DmacReq_Reg_en}); end
        DmacReq = 2'b00;
        do_reset();
    endtask

    task automatic test_reset_in_xfer();
        cyc(); DmacReq = 2'b01; C_config = 1'b0; #4;
        for (int i = 0; i < 6; i++) begin cyc(); DmacReq = 2'b00; end
        cyc(); #4;
        checks++; if (channel_en_1 !== 1'b1) begin errors++; $display("FAIL rx_pre got %b exp 1", channel_en_1); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({channel_en_1, channel_en_2, con_sel, dmac_busy} !== 5'b00100) begin errors++; $display("FAIL rx_async got %b exp 00100", {channel_en_1, channel_en_2, con_sel, dmac_busy}); end
        cyc();
        #2 rst = 1'b0;
        cyc(); #4;
        checks++; if ({dmac_busy, channel_en_1, DmacAck} !== 4'b0000) begin errors++; $display("FAIL rx_after got %b exp 0000", {dmac_busy, channel_en_1, DmacAck}); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_channel2();
        test_hready_stall();
        test_hresp_error();
        test_back_to_back();
        test_reset_in_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
